// File: rtl/ub_ctrl_pkg.sv
// Shared types and sizing for the unified-buffer access controller.
package ub_ctrl_pkg;

  localparam int unsigned GROUP    = 4;
  localparam int unsigned UB_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ST_ISSUE = 2'd1,
    LD_ISSUE = 2'd2,
    LD_WAIT  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_STORE = 1'b0,
    GNT_LOAD  = 1'b1
  } grant_t;

endpackage

// File: rtl/ub_rr_arbiter.sv
// Two-way round-robin arbiter between the store and load requesters.
// The grant history only advances when the controller is idle and grants.
module ub_rr_arbiter
  import ub_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic st_req_i,
  input  logic ld_req_i,
  input  logic en_i,
  output logic gnt_st_c,
  output logic gnt_ld_c
);

  grant_t last_grant_q;

  // Contention goes to the side that did not win last time
  always_comb begin
    gnt_st_c = 1'b0;
    gnt_ld_c = 1'b0;
    if (en_i) begin
      if (st_req_i && ld_req_i) begin
        if (last_grant_q == GNT_LOAD) gnt_st_c = 1'b1;
        else                          gnt_ld_c = 1'b1;
      end else begin
        gnt_st_c = st_req_i;
        gnt_ld_c = ld_req_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GNT_LOAD;
    end else if (gnt_st_c) begin
      last_grant_q <= GNT_STORE;
    end else if (gnt_ld_c) begin
      last_grant_q <= GNT_LOAD;
    end
  end

endmodule

// File: rtl/ub_access_ctrl.sv
// Serialises store and load accesses to the unified buffer, owns the store
// write pointer and its region wrap. Outputs are registered with the state.
module ub_access_ctrl #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned UB_DEPTH    = ub_ctrl_pkg::UB_DEPTH,
  parameter int unsigned GROUP       = ub_ctrl_pkg::GROUP,
  parameter int unsigned STORE_BASE  = 0,
  parameter int unsigned STORE_LIMIT = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_req,
  output logic              st_ack,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ack,
  output logic              ld_valid,
  output logic              ld_err,
  input  logic              ptr_clear,
  output logic [ADDR_W-1:0] ub_addr,
  output logic              ub_store,
  output logic              ub_load_input,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              st_wrapped,
  output logic              busy
);

  import ub_ctrl_pkg::state_t;
  import ub_ctrl_pkg::IDLE;
  import ub_ctrl_pkg::ST_ISSUE;
  import ub_ctrl_pkg::LD_ISSUE;
  import ub_ctrl_pkg::LD_WAIT;

  localparam logic [ADDR_W-1:0] GROUP_A  = ADDR_W'(GROUP);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(STORE_BASE);
  localparam logic [ADDR_W-1:0] LIMIT_A  = ADDR_W'(STORE_LIMIT);
  localparam logic [ADDR_W-1:0] LD_MAX_A = ADDR_W'(UB_DEPTH - GROUP);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [ADDR_W-1:0] ub_addr_q, ub_addr_d;
  logic              st_wrapped_q, st_wrapped_d;
  logic              st_ack_q, st_ack_d;
  logic              ld_ack_q, ld_ack_d;
  logic              ld_valid_q, ld_valid_d;
  logic              ld_err_q, ld_err_d;
  logic              ub_store_q, ub_store_d;
  logic              ub_load_q, ub_load_d;
  logic              busy_q, busy_d;
  logic              gnt_st_c, gnt_ld_c;

  ub_rr_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .st_req_i (st_req),
    .ld_req_i (ld_req),
    .en_i     (state_q == IDLE),
    .gnt_st_c (gnt_st_c),
    .gnt_ld_c (gnt_ld_c)
  );

  assign wr_ptr_inc = wr_ptr_q + GROUP_A;

  // Next state plus the output values that belong to the state being entered
  always_comb begin
    state_d      = state_q;
    ld_addr_d    = ld_addr_q;
    wr_ptr_d     = wr_ptr_q;
    st_wrapped_d = st_wrapped_q;
    ub_addr_d    = '0;
    ub_store_d   = 1'b0;
    ub_load_d    = 1'b0;
    st_ack_d     = 1'b0;
    ld_ack_d     = 1'b0;
    ld_valid_d   = 1'b0;
    ld_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_st_c) begin
          state_d    = ST_ISSUE;
          ub_store_d = 1'b1;
          st_ack_d   = 1'b1;
          ub_addr_d  = ptr_clear ? BASE_A : wr_ptr_q;
        end else if (gnt_ld_c) begin
          state_d   = LD_ISSUE;
          ld_addr_d = ld_addr;
          ld_ack_d  = 1'b1;
          if (ld_addr > LD_MAX_A) begin
            ld_err_d = 1'b1;
          end else begin
            ub_load_d = 1'b1;
            ub_addr_d = ld_addr;
          end
        end
      end
      ST_ISSUE: begin
        state_d = IDLE;
        if (wr_ptr_inc >= LIMIT_A) begin
          wr_ptr_d     = BASE_A;
          st_wrapped_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_inc;
        end
      end
      LD_ISSUE: begin
        if (ld_addr_q > LD_MAX_A) begin
          state_d = IDLE;
        end else begin
          state_d    = LD_WAIT;
          ld_valid_d = 1'b1;
        end
      end
      LD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A clear overrides any pointer advance in the same cycle
    if (ptr_clear) begin
      wr_ptr_d     = BASE_A;
      st_wrapped_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ld_addr_q    <= '0;
      wr_ptr_q     <= BASE_A;
      st_wrapped_q <= 1'b0;
      ub_addr_q    <= '0;
      ub_store_q   <= 1'b0;
      ub_load_q    <= 1'b0;
      st_ack_q     <= 1'b0;
      ld_ack_q     <= 1'b0;
      ld_valid_q   <= 1'b0;
      ld_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_addr_q    <= ld_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      st_wrapped_q <= st_wrapped_d;
      ub_addr_q    <= ub_addr_d;
      ub_store_q   <= ub_store_d;
      ub_load_q    <= ub_load_d;
      st_ack_q     <= st_ack_d;
      ld_ack_q     <= ld_ack_d;
      ld_valid_q   <= ld_valid_d;
      ld_err_q     <= ld_err_d;
      busy_q       <= busy_d;
    end
  end

  assign st_ack        = st_ack_q;
  assign ld_ack        = ld_ack_q;
  assign ld_valid      = ld_valid_q;
  assign ld_err        = ld_err_q;
  assign ub_addr       = ub_addr_q;
  assign ub_store      = ub_store_q;
  assign ub_load_input = ub_load_q;
  assign wr_ptr        = wr_ptr_q;
  assign st_wrapped    = st_wrapped_q;
  assign busy          = busy_q;

endmodule
